bsg_mul_rr_share: RTL and testbench
===================================

Name: bsg_mul_rr_share

Overview:
- Shares one 32x32 multiplier datapath among num_req_p requesters.
- Round-robin arbitration at the input; a lat_p-stage registered product pipeline; one tagged result output with a valid/yumi handshake.
- Sits between several compute clients and a single multiplier. The multiplier is instantiated inside this block, and the pipeline registers wrap it.
- Throughput is one product per cycle when no backpressure is applied.

Parameters:
- width_p, 32, operand width; the product is 2*width_p bits.
- num_req_p, 4, number of requesters (2..8).
- lat_p, 2, product pipeline depth in cycles (1..4), from accept to v_o.
- id_width_lp, `BSG_SAFE_CLOG2(num_req_p), localparam, width of the requester tag.

Ports:
- clk_i  input  1  sole clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  num_req_p  per-requester operand valid.
- a_i  input  num_req_p*width_p  packed operand A; requester k occupies bits [k*width_p +: width_p].
- b_i  input  num_req_p*width_p  packed operand B; same packing as a_i.
- ready_o  output  num_req_p  one-hot or zero; requester k's operands are accepted this cycle.
- v_o  output  1  result valid.
- id_o  output  id_width_lp  requester index of the result.
- c_o  output  2*width_p  product a*b.
- yumi_i  input  1  consumer takes the result this cycle; legal only when v_o=1.

Behaviour:
- Reset is synchronous, active-high (reset_i sampled on the clk_i edge).
  - During and after reset: all stage valids = 0, v_o=0, id_o=0, c_o=0, ready_o=0 while reset_i=1, RR pointer=0.
  - Reset mid-operation discards all in-flight products; nothing is emitted for them.
- Pipeline: stages s0..s(lat_p-1), each holding {valid, id, product}. The last stage drives v_o, id_o and c_o.
- Product is computed combinationally from the granted operands and registered into s0.
- advance = ~v_o | yumi_i. When advance=1, every stage shifts one step. When advance=0, the whole pipe holds.
  - Bubbles are not compressed while stalled; the stall is global.
- Grant:
  - Round-robin over v_i, starting search at the pointer and wrapping at num_req_p-1 -> 0.
  - ready_o[k] = grant[k] & advance & ~reset_i.
  - Accept for requester k means v_i[k] & ready_o[k]. On accept, the pointer moves to (k+1) mod num_req_p. With no accept, the pointer holds.
  - ready_o may combinationally depend on v_i. Requesters must not make v_i depend on ready_o.
  - Once v_i[k]=1, requester k holds its operands stable until accepted.
- Stage entry: on advance, s0.valid = accept, s0.id = granted index, s0.product = a*b.
  - If no accept, s0 loads valid=0; id and product are don't-care but must not be X at outputs after reset.
- Latency: accept at edge t gives v_o=1 after edge t+lat_p-1, i.e. visible in cycle t+lat_p, absent stalls.
- Output hold: while v_o=1 and yumi_i=0, v_o, id_o and c_o are held constant.
- Arithmetic: unsigned by default, full 2*width_p result with no truncation.
- Simultaneous events:
  - yumi_i on the final result while a new accept occurs: both happen in the same cycle.
  - No requests pending: bubbles flow through and v_o drops after the last result is taken.
- Starvation: a continuously-valid requester is granted within num_req_p accepts.

Optional Feature:
- Macro: BSG_MUL_RR_SHARE_SIGNED_EN.
- Defined: operands are treated as two's complement, and c_o is the signed 2*width_p product.
- Undefined: unsigned product.
- Arbitration, latency and handshake are identical in both builds.

Test Plan:
- Reset/idle: hold reset_i 3 cycles with v_i=4'b1111 -> ready_o=0, v_o=0. Release with v_i=0 -> v_o stays 0.
- Single request: lat_p=2, yumi_i=1; v_i[2]=1, a=3, b=5 -> accepted next edge; v_o=1, id_o=2, c_o=15 exactly 2 cycles after accept.
- Fairness: all four v_i held high with random operands, yumi_i=1 -> accept order 0,1,2,3,0,1..., one result per cycle, ids in the same order.
- Backpressure: yumi_i=0 for 5 cycles with results in flight -> ready_o=0, c_o/id_o stable, no loss or duplication. On release, results drain in order.
- Width corner: a=b=0xFFFFFFFF -> c_o=0xFFFFFFFE00000001 (unsigned build). In the signed build the same operands give c_o=1; a=0xFFFFFFFE, b=3 -> c_o=0xFFFFFFFFFFFFFFFA.
- Reset mid-flight: assert reset_i with 2 products in flight -> v_o=0 next cycle, pointer=0, no stale result emitted after release.

Source files
------------

// File: rtl/bsg_mul_rr_share.sv
// bsg_mul_rr_share: one 32x32 multiplier shared by num_req_p requesters.
// Requesters are served round-robin. Each accepted pair is multiplied and
// the product passes through lat_p registered stages, then leaves tagged
// with the requester's index.
//
// Ports:
//   clk_i, reset_i     clock; synchronous active-high reset
//   v_i[num_req_p]     per-requester operand valid
//   a_i, b_i           packed operands, requester k at [k*width_p +: width_p]
//   ready_o            one-hot grant, qualified by pipeline advance
//   v_o, id_o, c_o     result valid, requester tag, 2*width_p product
//   yumi_i             consumer takes the result (only while v_o=1)
//
// Build option: define BSG_MUL_RR_SHARE_SIGNED_EN to treat the operands as
// two's complement and produce a signed product. When it is undefined the
// product is unsigned.
module bsg_mul_rr_share #(
    parameter int width_p     = 32,
    parameter int num_req_p   = 4,
    parameter int lat_p       = 2,
    localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [num_req_p-1:0]          v_i,
    input  logic [num_req_p*width_p-1:0]  a_i,
    input  logic [num_req_p*width_p-1:0]  b_i,
    output logic [num_req_p-1:0]          ready_o,
    output logic                          v_o,
    output logic [id_width_lp-1:0]        id_o,
    output logic [2*width_p-1:0]          c_o,
    input  logic                          yumi_i
);

    logic [id_width_lp-1:0] ptr_r;

    logic [lat_p-1:0]       st_v_r;
    logic [id_width_lp-1:0] st_id_r [lat_p];
    logic [2*width_p-1:0]   st_p_r  [lat_p];

    logic                   advance;
    logic                   any_grant;
    logic                   accept;
    logic [num_req_p-1:0]   grant;
    logic [id_width_lp-1:0] gidx;
    logic [width_p-1:0]     a_sel;
    logic [width_p-1:0]     b_sel;
    logic [2*width_p-1:0]   a_ext;
    logic [2*width_p-1:0]   b_ext;
    logic [2*width_p-1:0]   prod;
    int                     k;

    // The stall is global: the whole pipe holds while the result waits.
    assign advance = ~v_o | yumi_i;

    // Round-robin search starting at the pointer, wrapping at the top.
    always_comb begin
        grant     = '0;
        gidx      = '0;
        any_grant = 1'b0;
        a_sel     = '0;
        b_sel     = '0;
        k         = 0;
        for (int i = 0; i < num_req_p; i++) begin
            k = int'(ptr_r) + i;
            if (k >= num_req_p) k = k - num_req_p;
            if (!any_grant && v_i[k]) begin
                any_grant = 1'b1;
                grant[k]  = 1'b1;
                gidx      = id_width_lp'(k);
                a_sel     = a_i[k*width_p +: width_p];
                b_sel     = b_i[k*width_p +: width_p];
            end
        end
    end

    assign ready_o = grant & {num_req_p{advance & ~reset_i}};
    assign accept  = any_grant & advance & ~reset_i;

    // Operands are widened to the full product width, so the low
    // 2*width_p bits of the product are exact in either build.
`ifdef BSG_MUL_RR_SHARE_SIGNED_EN
    assign a_ext = {{width_p{a_sel[width_p-1]}}, a_sel};
    assign b_ext = {{width_p{b_sel[width_p-1]}}, b_sel};
`else
    assign a_ext = {{width_p{1'b0}}, a_sel};
    assign b_ext = {{width_p{1'b0}}, b_sel};
`endif

    assign prod = a_ext * b_ext;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r <= '0;
        end else if (accept) begin
            if (gidx == id_width_lp'(num_req_p - 1))
                ptr_r <= '0;
            else
                ptr_r <= gidx + id_width_lp'(1);
        end
    end

    // Idle slots also load the id and product, which keeps every stage
    // free of X from reset onward.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_v_r <= '0;
            for (int s = 0; s < lat_p; s++) begin
                st_id_r[s] <= '0;
                st_p_r[s]  <= '0;
            end
        end else if (advance) begin
            st_v_r[0]  <= accept;
            st_id_r[0] <= gidx;
            st_p_r[0]  <= prod;
            for (int s = 1; s < lat_p; s++) begin
                st_v_r[s]  <= st_v_r[s-1];
                st_id_r[s] <= st_id_r[s-1];
                st_p_r[s]  <= st_p_r[s-1];
            end
        end
    end

    assign v_o  = st_v_r[lat_p-1];
    assign id_o = st_id_r[lat_p-1];
    assign c_o  = st_p_r[lat_p-1];

endmodule

// File: tb/tb_bsg_mul_rr_share.sv
// tb_bsg_mul_rr_share: directed checks of bsg_mul_rr_share
// (num_req_p=4, lat_p=2, width_p=32).
module tb_bsg_mul_rr_share;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [3:0]  v_i;
    logic [127:0] a_i;
    logic [127:0] b_i;
    logic [3:0]  ready_o;
    logic        v_o;
    logic [1:0]  id_o;
    logic [63:0] c_o;
    logic        yumi_i;

    int tests = 0;
    int fails = 0;

    logic [31:0] a_v [4];
    logic [31:0] b_v [4];
    logic [63:0] p_v [4];

    bsg_mul_rr_share #(.width_p(32), .num_req_p(4), .lat_p(2)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .id_o    (id_o),
        .c_o     (c_o),
        .yumi_i  (yumi_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load_table();
        for (int j = 0; j < 4; j++) begin
            a_i[j*32 +: 32] = a_v[j];
            b_i[j*32 +: 32] = b_v[j];
        end
    endtask

    initial begin
        a_v[0] = 32'd7;        b_v[0] = 32'd9;       p_v[0] = 64'd63;
        a_v[1] = 32'h10;       b_v[1] = 32'h20;      p_v[1] = 64'h200;
        a_v[2] = 32'hFFFF;     b_v[2] = 32'h10001;   p_v[2] = 64'hFFFF_FFFF;
        a_v[3] = 32'h12345678; b_v[3] = 32'd2;       p_v[3] = 64'h2468_ACF0;

        reset_i = 1'b1;
        v_i     = 4'b1111;
        a_i     = '0;
        b_i     = '0;
        yumi_i  = 1'b1;

        // reset with all requesters valid
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            check("rst_ready", 64'(ready_o), 64'd0);
            check("rst_v", 64'(v_o), 64'd0);
        end
        cyc();
        reset_i = 1'b0;
        v_i     = 4'b0000;
        cyc();
        cyc();
        check("idle_v", 64'(v_o), 64'd0);
        check("idle_id", 64'(id_o), 64'd0);
        check("idle_c", c_o, 64'd0);

        // single request from requester 2
        a_i[2*32 +: 32] = 32'd3;
        b_i[2*32 +: 32] = 32'd5;
        v_i = 4'b0100;
        #1;
        check("single_ready", 64'(ready_o), 64'b0100);
        cyc();
        v_i = 4'b0000;
        check("single_v_early", 64'(v_o), 64'd0);
        cyc();
        check("single_v", 64'(v_o), 64'd1);
        check("single_id", 64'(id_o), 64'd2);
        check("single_c", c_o, 64'd15);
        cyc();
        check("single_gone", 64'(v_o), 64'd0);

        // reset returns the pointer to 0
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;

        // fairness with all four requesters valid
        load_table();
        v_i = 4'b1111;
        for (int j = 0; j < 11; j++) begin
            if (j == 8) v_i = 4'b0000;
            #1;
            if (j < 8)
                check("rr_ready", 64'(ready_o), 64'(4'b0001 << (j % 4)));
            if (j >= 2 && j < 10) begin
                check("rr_v", 64'(v_o), 64'd1);
                check("rr_id", 64'(id_o), 64'((j - 2) % 4));
                check("rr_c", c_o, p_v[(j - 2) % 4]);
            end
            if (j == 10) check("rr_drained", 64'(v_o), 64'd0);
            cyc();
        end

        // backpressure: pointer is back at 0
        v_i    = 4'b1111;
        yumi_i = 1'b0;
        #1;
        check("bp_ready0", 64'(ready_o), 64'b0001);
        cyc();
        #1;
        check("bp_ready1", 64'(ready_o), 64'b0010);
        cyc();
        for (int j = 0; j < 5; j++) begin
            #1;
            check("bp_ready_stall", 64'(ready_o), 64'd0);
            check("bp_v", 64'(v_o), 64'd1);
            check("bp_id", 64'(id_o), 64'd0);
            check("bp_c", c_o, p_v[0]);
            cyc();
        end
        v_i    = 4'b0000;
        yumi_i = 1'b1;
        cyc();
        check("bp_drain_v", 64'(v_o), 64'd1);
        check("bp_drain_id", 64'(id_o), 64'd1);
        check("bp_drain_c", c_o, p_v[1]);
        cyc();
        check("bp_empty", 64'(v_o), 64'd0);

        // width corners; pointer now at 2, so requester 0 wins first
        a_i[0 +: 32]  = 32'hFFFF_FFFF;
        b_i[0 +: 32]  = 32'hFFFF_FFFF;
        a_i[32 +: 32] = 32'hFFFF_FFFE;
        b_i[32 +: 32] = 32'd3;
        v_i = 4'b0011;
        #1;
        check("wc_ready0", 64'(ready_o), 64'b0001);
        cyc();
        v_i = 4'b0010;
        #1;
        check("wc_ready1", 64'(ready_o), 64'b0010);
        cyc();
        v_i = 4'b0000;
        check("wc_id0", 64'(id_o), 64'd0);
`ifdef BSG_MUL_RR_SHARE_SIGNED_EN
        check("wc_c0", c_o, 64'd1);
`else
        check("wc_c0", c_o, 64'hFFFF_FFFE_0000_0001);
`endif
        cyc();
        check("wc_id1", 64'(id_o), 64'd1);
`ifdef BSG_MUL_RR_SHARE_SIGNED_EN
        check("wc_c1", c_o, 64'hFFFF_FFFF_FFFF_FFFA);
`else
        check("wc_c1", c_o, 64'h0000_0002_FFFF_FFFA);
`endif
        cyc();

        // reset with two products in flight; pointer now at 2
        load_table();
        v_i = 4'b1111;
        #1;
        check("mr_ready2", 64'(ready_o), 64'b0100);
        cyc();
        #1;
        check("mr_ready3", 64'(ready_o), 64'b1000);
        cyc();
        check("mr_v_before", 64'(v_o), 64'd1);
        check("mr_id_before", 64'(id_o), 64'd2);
        reset_i = 1'b1;
        v_i     = 4'b0000;
        #1;
        check("mr_ready_rst", 64'(ready_o), 64'd0);
        cyc();
        check("mr_v", 64'(v_o), 64'd0);
        check("mr_c", c_o, 64'd0);
        reset_i = 1'b0;
        v_i     = 4'b1111;
        #1;
        check("mr_ptr0", 64'(ready_o), 64'b0001);
        cyc();
        v_i = 4'b0000;
        check("mr_no_stale", 64'(v_o), 64'd0);
        cyc();
        check("mr_new_v", 64'(v_o), 64'd1);
        check("mr_new_id", 64'(id_o), 64'd0);
        check("mr_new_c", c_o, p_v[0]);
        cyc();
        check("mr_end", 64'(v_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
